// File: rtl/exor_sched_pkg.sv
// Shared definitions for the round-robin XOR scheduler: state encoding and
// default sizing.
package exor_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/exor_rr_scheduler_if.sv
// Requester-side bus of the scheduler: level requests with packed operands in,
// one-hot grant and completion report out.
interface exor_rr_scheduler_if #(
    parameter int NREQ  = exor_sched_pkg::DEF_NREQ,
    parameter int WIDTH = exor_sched_pkg::DEF_WIDTH
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat;
    logic [NREQ*WIDTH-1:0] b_flat;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         done_id;
    logic [WIDTH-1:0]      result;

    modport master (
        output req, a_flat, b_flat,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, a_flat, b_flat,
        output gnt, busy, done, done_id, result
    );

endinterface

// File: rtl/specific_exor.sv
// The shared single-bit XOR datapath cell.
module specific_exor (
    input  logic s,
    input  logic t,
    output logic f
);

    assign f = s ^ t;

endmodule

// File: rtl/exor_rr_scheduler.sv
// Time-shares one specific_exor cell among NREQ requesters: round-robin grant,
// LSB-first bit-serial XOR over WIDTH cycles, then a one-cycle done pulse.
module exor_rr_scheduler
    import exor_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    exor_rr_scheduler_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    last;
    logic [WIDTH-1:0] sa, sb, acc, acc_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic             done;
    logic [IW-1:0]    done_id;
    logic             f;
    logic [IW:0]      pick;

    // First set request searching upward from last+1 with wrap; MSB = found.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   from);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(from) + k) % NREQ;
            if (r[j]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    assign pick = rr_pick(bus.req, last);

    specific_exor u_cell (
        .s (sa[0]),
        .t (sb[0]),
        .f (f)
    );

    generate
        if (WIDTH > 1) begin : g_acc_wide
            assign acc_next = {f, acc[WIDTH-1:1]};
        end else begin : g_acc_bit
            assign acc_next = f;
        end
    endgenerate

    // The final accumulator value is latched into result on the edge that
    // enters DONE, so done/result are visible throughout the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            sel     <= '0;
            last    <= IW'(NREQ - 1);
            sa      <= '0;
            sb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick[IW]) begin
                        sel   <= pick[IW-1:0];
                        gnt   <= NREQ'(1) << pick[IW-1:0];
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sa    <= bus.a_flat[sel*WIDTH +: WIDTH];
                    sb    <= bus.b_flat[sel*WIDTH +: WIDTH];
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        gnt     <= '0;
                        result  <= acc_next;
                        done    <= 1'b1;
                        done_id <= sel;
                        last    <= sel;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done;
    assign bus.done_id = done_id;
    assign bus.result  = result;

endmodule
